cov_monitor: RTL and testbench

COV_MONITOR -- requirements
Module: cov_monitor

---
 rtl/cov_monitor_if.sv | 27 ++
 rtl/cov_monitor.sv | 125 ++++++++++++
 tb/tb_cov_monitor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cov_monitor_if.sv
// Bundle of sampling, clear and readback signals shared between cov_monitor and its driver.
interface cov_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             a;
    logic             b;
    logic             c;
    logic             sample_en;
    logic             clr;
    logic             rd_req;
    logic [2:0]       rd_sel;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic [7:0]       hit_mask;
    logic             all_hit;
    logic             seq_hit;

    modport master (
        output a, b, c, sample_en, clr, rd_req, rd_sel,
        input  rd_valid, rd_data, hit_mask, all_hit, seq_hit
    );

    modport slave (
        input  a, b, c, sample_en, clr, rd_req, rd_sel,
        output rd_valid, rd_data, hit_mask, all_hit, seq_hit
    );
endinterface

// File: rtl/cov_monitor.sv
// Functional-coverage monitor: eight saturating bin counters indexed by {a,b,c}, a hit mask,
// a registered readback port and a sticky detector for the ordered sample sequence 001->011->111.
module cov_monitor #(
    parameter int CNT_W = 8
) (
    input  logic          CLK,
    input  logic          RSTn,
    cov_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GOT1 = 2'd1,
        S_GOT2 = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    logic [CNT_W-1:0] r_cnt [8];
    logic [7:0]       r_hit_mask;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_seq_hit;
    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [2:0]       w_idx;
    logic             w_sample;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_idx    = {bus.a, bus.b, bus.c};
    // clr wins over a coincident sample, so the sample is simply never taken.
    assign w_sample = bus.sample_en & ~bus.clr;

    // Bin counters: saturating increment of the sampled bin.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (bus.clr) begin
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (w_sample) begin
            r_cnt[w_idx] <= sat_inc(r_cnt[w_idx]);
        end
    end

    // Hit mask: sticky per-bin flag.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_hit_mask <= 8'h00;
        end else if (bus.clr) begin
            r_hit_mask <= 8'h00;
        end else if (w_sample) begin
            r_hit_mask <= r_hit_mask | (8'h01 << w_idx);
        end
    end

    // Readback: returns the count as it stood before this edge's update, clr included.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= {CNT_W{1'b0}};
        end else begin
            r_rd_valid <= bus.rd_req;
            r_rd_data  <= bus.rd_req ? r_cnt[bus.rd_sel] : {CNT_W{1'b0}};
        end
    end

    // Sequence detector next state; only sample cycles move it.
    always_comb begin
        w_state_nxt = r_state;
        if (w_sample) begin
            case (r_state)
                S_IDLE:  w_state_nxt = (w_idx == 3'b001) ? S_GOT1 : S_IDLE;
                S_GOT1: begin
                    if (w_idx == 3'b011) begin
                        w_state_nxt = S_GOT2;
                    end else if (w_idx == 3'b001) begin
                        w_state_nxt = S_GOT1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_GOT2: begin
                    if (w_idx == 3'b111) begin
                        w_state_nxt = S_DONE;
                    end else if (w_idx == 3'b001) begin
                        w_state_nxt = S_GOT1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Sequence state register with its registered done flag.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= S_IDLE;
            r_seq_hit <= 1'b0;
        end else if (bus.clr) begin
            r_state   <= S_IDLE;
            r_seq_hit <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seq_hit <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.hit_mask = r_hit_mask;
    assign bus.all_hit  = (r_hit_mask == 8'hFF);
    assign bus.seq_hit  = r_seq_hit;

endmodule

// File: tb/tb_cov_monitor.sv
// Self-checking bench for cov_monitor: vector table plus hand sequences, reads scored via a queue.
module tb_cov_monitor;

    logic CLK;
    logic RSTn;
    int   n_vec;
    int   n_err;
    logic [7:0] sb[$];

    cov_monitor_if #(.CNT_W(8)) bus ();

    cov_monitor #(.CNT_W(8)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       se;
        logic [2:0] abc;
        logic       cl;
        logic       rd;
        logic [2:0] sel;
        logic [7:0] exp_rd;
        logic [7:0] exp_mask;
        logic       exp_all;
        logic       exp_seq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic se, input logic [2:0] abc, input logic cl,
                                 input logic rd, input logic [2:0] sel, input logic [7:0] exp_rd,
                                 input logic [7:0] exp_mask, input logic exp_all,
                                 input logic exp_seq);
        vec_t v;
        v.se = se; v.abc = abc; v.cl = cl; v.rd = rd; v.sel = sel; v.exp_rd = exp_rd;
        v.exp_mask = exp_mask; v.exp_all = exp_all; v.exp_seq = exp_seq;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, push expected read data, then score rd_valid/rd_data.
    task automatic step(input logic se, input logic [2:0] abc, input logic cl,
                        input logic rd, input logic [2:0] sel, input logic [7:0] exp_rd);
        logic [7:0] e;
        bus.sample_en = se;
        {bus.a, bus.b, bus.c} = abc;
        bus.clr    = cl;
        bus.rd_req = rd;
        bus.rd_sel = sel;
        if (rd) sb.push_back(exp_rd);
        @(posedge CLK);
        #1;
        bus.sample_en = 1'b0;
        bus.clr       = 1'b0;
        bus.rd_req    = 1'b0;
        chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, rd});
        if (bus.rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rd_data", {24'd0, bus.rd_data}, {24'd0, e});
            end
        end else begin
            chk("rd_data_idle", {24'd0, bus.rd_data}, 32'd0);
        end
    endtask

    task automatic chk_state(input logic [7:0] m, input logic al, input logic sq);
        chk("hit_mask", {24'd0, bus.hit_mask}, {24'd0, m});
        chk("all_hit", {31'd0, bus.all_hit}, {31'd0, al});
        chk("seq_hit", {31'd0, bus.seq_hit}, {31'd0, sq});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RSTn = 1'b0;
        bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b0;
        bus.sample_en = 1'b0; bus.clr = 1'b0; bus.rd_req = 1'b0; bus.rd_sel = 3'd0;

        // se, abc, clr, rd, sel, exp_rd, exp_mask, exp_all, exp_seq
        vecs.push_back(mkv(1'b1, 3'b001, 1'b0, 1'b0, 3'd0, 8'd0, 8'h02, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b011, 1'b0, 1'b0, 3'd0, 8'd0, 8'h0A, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0, 8'h8A, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b0, 3'b000, 1'b1, 1'b1, 3'd1, 8'd1, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b001, 1'b0, 1'b0, 3'd0, 8'd0, 8'h02, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b011, 1'b0, 1'b0, 3'd0, 8'd0, 8'h0A, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0, 8'h0B, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0, 8'h8B, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b001, 1'b0, 1'b0, 3'd0, 8'd0, 8'h8B, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b001, 1'b0, 1'b0, 3'd0, 8'd0, 8'h8B, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b011, 1'b0, 1'b0, 3'd0, 8'd0, 8'h8B, 1'b0, 1'b0));
        vecs.push_back(mkv(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0, 8'h8B, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b0, 3'b000, 1'b0, 1'b1, 3'd1, 8'd3, 8'h8B, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b0, 3'b000, 1'b0, 1'b1, 3'd7, 8'd2, 8'h8B, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 3'b011, 1'b0, 1'b1, 3'd3, 8'd2, 8'h8B, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b0, 3'b000, 1'b0, 1'b1, 3'd3, 8'd3, 8'h8B, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 3'b010, 1'b0, 1'b0, 3'd0, 8'd0, 8'h8F, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 3'b100, 1'b0, 1'b0, 3'd0, 8'd0, 8'h9F, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 3'b101, 1'b0, 1'b0, 3'd0, 8'd0, 8'hBF, 1'b0, 1'b1));
        vecs.push_back(mkv(1'b1, 3'b110, 1'b0, 1'b0, 3'd0, 8'd0, 8'hFF, 1'b1, 1'b1));
        vecs.push_back(mkv(1'b1, 3'b101, 1'b1, 1'b1, 3'd0, 8'd1, 8'h00, 1'b0, 1'b0));

        #12;
        chk_state(8'h00, 1'b0, 1'b0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].se, vecs[i].abc, vecs[i].cl, vecs[i].rd, vecs[i].sel, vecs[i].exp_rd);
            chk_state(vecs[i].exp_mask, vecs[i].exp_all, vecs[i].exp_seq);
        end

        // After clear every bin reads zero, including the bin sampled alongside clr.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'b000, 1'b0, 1'b1, 3'(i), 8'd0);
        end
        chk_state(8'h00, 1'b0, 1'b0);

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 3'b101, 1'b0, 1'b0, 3'd0, 8'd0);
        end
        step(1'b0, 3'b000, 1'b0, 1'b1, 3'd5, 8'd255);
        chk_state(8'h20, 1'b0, 1'b0);

        // Read coincident with a sample of the same bin.
        step(1'b0, 3'b000, 1'b1, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b011, 1'b0, 1'b0, 3'd0, 8'd0);
        end
        step(1'b1, 3'b011, 1'b0, 1'b1, 3'd3, 8'd4);
        step(1'b0, 3'b000, 1'b0, 1'b1, 3'd3, 8'd5);

        // Asynchronous reset with a read in flight and the detector in GOT2.
        step(1'b0, 3'b000, 1'b1, 1'b0, 3'd0, 8'd0);
        step(1'b1, 3'b001, 1'b0, 1'b0, 3'd0, 8'd0);
        step(1'b1, 3'b011, 1'b0, 1'b0, 3'd0, 8'd0);
        step(1'b0, 3'b000, 1'b0, 1'b1, 3'd2, 8'd0);
        bus.rd_req = 1'b1;
        bus.rd_sel = 3'd3;
        #2;
        RSTn = 1'b0;
        #1;
        chk("async_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("async_rd_data", {24'd0, bus.rd_data}, 32'd0);
        chk_state(8'h00, 1'b0, 1'b0);
        bus.rd_req = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        step(1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 8'd0);
        step(1'b1, 3'b111, 1'b0, 1'b0, 3'd0, 8'd0);
        chk_state(8'h80, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b1, 3'd1, 8'd0);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
